// File: rtl/scan_reporter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : scan_reporter
//  Description : Buffers {angle,distance} scan samples in a small FIFO and
//                serialises each one as a framed byte stream (0xA5, angle,
//                distance [, checksum]) to a CoreUART transmitter. Samples
//                arriving while the FIFO is full are dropped and counted.
//                Optional feature macro: SCAN_REPORTER_CHECKSUM_EN adds a
//                fourth byte (0xA5 ^ angle ^ distance) to every frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module scan_reporter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] angle,
    input  logic [7:0] distance,
    input  logic       txrdy,
    output logic       wen,
    output logic [7:0] data_in,
    output logic       overflow,
    output logic [7:0] drop_cnt,
    output logic       busy
);

    localparam int              c_ptr_w    = $clog2(FIFO_DEPTH);
    localparam logic [c_ptr_w:0] c_depth   = (c_ptr_w + 1)'(FIFO_DEPTH);
    localparam logic [7:0]      c_hdr_byte = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ANG  = 3'd2,
        ST_DIST = 3'd3,
`ifdef SCAN_REPORTER_CHECKSUM_EN
        ST_CSUM = 3'd5,
`endif
        ST_GAP  = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [15:0]        mem_q [FIFO_DEPTH];
    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_ptr_w:0]   count_q,  count_d;

    // Drop tracking
    logic               overflow_q, overflow_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    // Frame sequencer
    state_t             state_q, state_d;
    state_t             next_q,  next_d;
    logic [7:0]         frame_ang_q,  frame_ang_d;
    logic [7:0]         frame_dist_q, frame_dist_d;
    logic               wen_q,  wen_d;
    logic [7:0]         data_q, data_d;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic [15:0]        w_head;

    // Full is judged on the current occupancy, so a sample is dropped even
    // when the sequencer pops in the same cycle.
    assign w_full  = (count_q == c_depth);
    assign w_empty = (count_q == '0);
    assign w_push  = sample_valid && !w_full;
    assign w_drop  = sample_valid &&  w_full;
    assign w_pop   = (state_q == ST_IDLE) && !w_empty;
    assign w_head  = mem_q[rd_ptr_q];

    // FIFO pointer/occupancy update and drop counter next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = w_drop;
        drop_cnt_d = drop_cnt_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (w_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // FIFO payload storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= {angle, distance};
        end
    end

    // Frame sequencer next-state and registered UART outputs
    always_comb begin
        state_d      = state_q;
        next_d       = next_q;
        frame_ang_d  = frame_ang_q;
        frame_dist_d = frame_dist_q;
        wen_d        = 1'b0;
        data_d       = data_q;
        case (state_q)
            ST_IDLE: begin
                if (!w_empty) begin
                    {frame_ang_d, frame_dist_d} = w_head;
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (txrdy) begin
                    wen_d   = 1'b1;
                    data_d  = c_hdr_byte;
                    next_d  = ST_ANG;
                    state_d = ST_GAP;
                end
            end
            ST_ANG: begin
                if (txrdy) begin
                    wen_d   = 1'b1;
                    data_d  = frame_ang_q;
                    next_d  = ST_DIST;
                    state_d = ST_GAP;
                end
            end
            ST_DIST: begin
                if (txrdy) begin
                    wen_d   = 1'b1;
                    data_d  = frame_dist_q;
`ifdef SCAN_REPORTER_CHECKSUM_EN
                    next_d  = ST_CSUM;
`else
                    next_d  = ST_IDLE;
`endif
                    state_d = ST_GAP;
                end
            end
`ifdef SCAN_REPORTER_CHECKSUM_EN
            ST_CSUM: begin
                if (txrdy) begin
                    wen_d   = 1'b1;
                    data_d  = c_hdr_byte ^ frame_ang_q ^ frame_dist_q;
                    next_d  = ST_IDLE;
                    state_d = ST_GAP;
                end
            end
`endif
            ST_GAP: begin
                // One idle cycle between bytes regardless of txrdy
                state_d = next_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register for FIFO control, drop tracking and sequencer
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            drop_cnt_q   <= 8'd0;
            state_q      <= ST_IDLE;
            next_q       <= ST_IDLE;
            frame_ang_q  <= 8'd0;
            frame_dist_q <= 8'd0;
            wen_q        <= 1'b0;
            data_q       <= 8'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            drop_cnt_q   <= drop_cnt_d;
            state_q      <= state_d;
            next_q       <= next_d;
            frame_ang_q  <= frame_ang_d;
            frame_dist_q <= frame_dist_d;
            wen_q        <= wen_d;
            data_q       <= data_d;
        end
    end

    assign wen      = wen_q;
    assign data_in  = data_q;
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;
    assign busy     = (state_q != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_scan_reporter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_scan_reporter
//  Description : Directed self-checking bench for scan_reporter (depth 4).
//                Frame length follows SCAN_REPORTER_CHECKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scan_reporter;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [7:0] angle;
    logic [7:0] distance;
    logic       txrdy;
    logic       wen;
    logic [7:0] data_in;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    scan_reporter #(.FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .angle        (angle),
        .distance     (distance),
        .txrdy        (txrdy),
        .wen          (wen),
        .data_in      (data_in),
        .overflow     (overflow),
        .drop_cnt     (drop_cnt),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then read 1 ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {wen,data_in} packed for single comparisons
    function automatic logic [15:0] wd(input logic w, input logic [7:0] d);
        return 16'({w, d});
    endfunction

    task automatic strobe(input logic [7:0] a, input logic [7:0] d);
        sample_valid = 1'b1;
        angle        = a;
        distance     = d;
        tick();
        sample_valid = 1'b0;
    endtask

    // Wait (bounded) for a header, then check each byte 2 cycles apart
    task automatic expect_frame(input string tag, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!wen && n < 16);
        check({tag, "_hdr"},  wd(wen, data_in), wd(1'b1, 8'hA5));
        tick(); check({tag, "_gap1"}, wd(wen, 8'h00), wd(1'b0, 8'h00));
        tick(); check({tag, "_ang"},  wd(wen, data_in), wd(1'b1, a));
        tick(); check({tag, "_gap2"}, wd(wen, 8'h00), wd(1'b0, 8'h00));
        tick(); check({tag, "_dist"}, wd(wen, data_in), wd(1'b1, d));
`ifdef SCAN_REPORTER_CHECKSUM_EN
        tick(); check({tag, "_gap3"}, wd(wen, 8'h00), wd(1'b0, 8'h00));
        tick(); check({tag, "_csum"}, wd(wen, data_in), wd(1'b1, 8'hA5 ^ a ^ d));
`endif
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 16'(busy), 16'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int wen_seen;
        rst          = 1'b1;
        sample_valid = 1'b0;
        angle        = 8'h00;
        distance     = 8'h00;
        txrdy        = 1'b1;

        // Reset state
        tick(); tick(); tick();
        check("rst_wen",      16'(wen),      16'd0);
        check("rst_data",     16'(data_in),  16'h00);
        check("rst_overflow", 16'(overflow), 16'd0);
        check("rst_drop",     16'(drop_cnt), 16'd0);
        check("rst_busy",     16'(busy),     16'd0);
        rst = 1'b0;
        tick();

        // Single sample: header 2 cycles after strobe, bytes 2 cycles apart
        strobe(8'h5A, 8'h20);
        check("lat_busy", 16'(busy), 16'd1);
        check("lat_e0",   wd(wen, 8'h00), wd(1'b0, 8'h00));
        tick(); check("lat_e1",   wd(wen, 8'h00), wd(1'b0, 8'h00));
        tick(); check("lat_hdr",  wd(wen, data_in), wd(1'b1, 8'hA5));
        tick(); check("lat_gap1", wd(wen, data_in), wd(1'b0, 8'hA5));
        tick(); check("lat_ang",  wd(wen, data_in), wd(1'b1, 8'h5A));
        tick(); check("lat_gap2", wd(wen, data_in), wd(1'b0, 8'h5A));
        tick(); check("lat_dist", wd(wen, data_in), wd(1'b1, 8'h20));
`ifdef SCAN_REPORTER_CHECKSUM_EN
        tick(); check("lat_gap3", wd(wen, data_in), wd(1'b0, 8'h20));
        tick(); check("lat_csum", wd(wen, data_in), wd(1'b1, 8'hDF));
`endif
        wait_idle("lat");

        // Stall in ANG for 10 cycles with txrdy=0
        strobe(8'h5A, 8'h20);
        tick(); tick();
        check("stall_hdr", wd(wen, data_in), wd(1'b1, 8'hA5));
        txrdy = 1'b0;
        tick();
        wen_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (wen) wen_seen++;
        end
        check("stall_nowen", 16'(wen_seen), 16'd0);
        check("stall_hold",  16'(data_in),  16'hA5);
        txrdy = 1'b1;
        tick(); check("stall_ang", wd(wen, data_in), wd(1'b1, 8'h5A));
        tick(); tick();
        check("stall_dist", wd(wen, data_in), wd(1'b1, 8'h20));
        wait_idle("stall");

        // Overflow: first sample parks in the frame register (txrdy=0),
        // then 6 strobes fill the 4-entry FIFO and drop 2
        txrdy = 1'b0;
        strobe(8'h11, 8'h22);
        tick(); tick();
        sample_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            angle    = 8'h30 + 8'(i);
            distance = 8'h40 + 8'(i);
            tick();
            check($sformatf("ovf_pulse%0d", i), 16'(overflow), (i >= 4) ? 16'd1 : 16'd0);
        end
        sample_valid = 1'b0;
        tick();
        check("ovf_clear", 16'(overflow), 16'd0);
        check("ovf_drop",  16'(drop_cnt), 16'd2);
        txrdy = 1'b1;
        expect_frame("ovf_f0", 8'h11, 8'h22);
        for (int i = 0; i < 4; i++) begin
            expect_frame($sformatf("ovf_f%0d", i + 1), 8'h30 + 8'(i), 8'h40 + 8'(i));
        end
        wait_idle("ovf");

        // drop_cnt saturation: 1 parked + 4 stored, strobe n>=6 drops
        do_reset();
        txrdy        = 1'b0;
        sample_valid = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            angle    = 8'(n);
            distance = 8'(n);
            tick();
            if (n == 259) check("sat_254", 16'(drop_cnt), 16'd254);
        end
        sample_valid = 1'b0;
        check("sat_255",      16'(drop_cnt), 16'd255);
        check("sat_overflow", 16'(overflow), 16'd1);

        // Reset mid-frame after header; coincident strobe ignored
        txrdy = 1'b1;
        do_reset();
        strobe(8'h5A, 8'h20);
        tick(); tick();
        check("mid_hdr", wd(wen, data_in), wd(1'b1, 8'hA5));
        rst          = 1'b1;
        sample_valid = 1'b1;
        angle        = 8'h77;
        distance     = 8'h66;
        tick();
        rst          = 1'b0;
        sample_valid = 1'b0;
        check("mid_wen",  16'(wen),      16'd0);
        check("mid_data", 16'(data_in),  16'h00);
        check("mid_busy", 16'(busy),     16'd0);
        check("mid_drop", 16'(drop_cnt), 16'd0);
        wen_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wen) wen_seen++;
        end
        check("mid_nowen", 16'(wen_seen), 16'd0);
        check("mid_busy2", 16'(busy),     16'd0);
        strobe(8'h3C, 8'hC3);
        expect_frame("post", 8'h3C, 8'hC3);
        wait_idle("post");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
